// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encoding,
// requester index map and default sizing.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_BUSY    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    localparam int REQ_ICACHE = 0;
    localparam int REQ_DCACHE = 1;
    localparam int REQ_IO     = 2;
    localparam int REQ_DMA    = 3;

    localparam int DEF_NUM_REQ       = 4;
    localparam int DEF_ID_W          = 2;
    localparam int DEF_GRANT_TIMEOUT = 8;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Round-robin picker: returns the first set request found scanning upward
// from rr_ptr, wrapping at NUM_REQ (not at 2**ID_W). Purely combinational.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [ID_W-1:0]    sel,
    output logic               valid
);

    // One extra bit so rr_ptr + offset never overflows before the wrap.
    logic [ID_W:0] idx;

    // Scan offsets 0..NUM_REQ-1 from the pointer and keep the first hit.
    always_comb begin
        sel   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(NUM_REQ)) begin
                idx = idx - (ID_W+1)'(NUM_REQ);
            end
            if (!valid && req[idx[ID_W-1:0]]) begin
                valid = 1'b1;
                sel   = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: grants the shared interconnect to one requester at a
// time (round-robin), follows the owner's busy handshake, inserts one dead
// turnaround cycle between owners and revokes grants never used.
// Build option: MEM_ARB_DCACHE_PRIO_EN gives the dcache absolute priority in
// IDLE; dcache grants then leave the round-robin pointer untouched.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ       = DEF_NUM_REQ,
    parameter int ID_W          = DEF_ID_W,
    parameter int GRANT_TIMEOUT = DEF_GRANT_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] busy,
    output logic [NUM_REQ-1:0] grant,
    output logic               bus_busy,
    output logic [ID_W-1:0]    owner_id,
    output logic               timeout_err
);

    localparam int TMR_W = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    arb_state_t       state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  next_ptr;
    logic [ID_W-1:0]  rr_sel;
    logic [ID_W-1:0]  pick_sel;
    logic             rr_valid;
    logic             pick_valid;
    logic [TMR_W-1:0] timer;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .sel    (rr_sel),
        .valid  (rr_valid)
    );

    // Final winner of an IDLE arbitration, with the optional dcache override.
    always_comb begin
        pick_sel   = rr_sel;
        pick_valid = rr_valid;
`ifdef MEM_ARB_DCACHE_PRIO_EN
        if (req[REQ_DCACHE]) begin
            pick_sel   = ID_W'(REQ_DCACHE);
            pick_valid = 1'b1;
        end
`endif
    end

    // Requester following the current owner, wrapping at NUM_REQ.
    always_comb begin
        next_ptr = (int'(owner_id) == NUM_REQ - 1) ? '0 : owner_id + 1'b1;
    end

    // Arbitration FSM with grant timer; every output is a register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            grant       <= '0;
            bus_busy    <= 1'b0;
            owner_id    <= '0;
            timeout_err <= 1'b0;
            rr_ptr      <= '0;
            timer       <= '0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant    <= ONE << pick_sel;
                        owner_id <= pick_sel;
                        timer    <= '0;
                        state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // busy beats withdraw, withdraw beats timeout
                    if (busy[owner_id]) begin
                        bus_busy <= 1'b1;
                        state    <= ST_BUSY;
                    end else if (!req[owner_id]) begin
                        grant <= '0;
                        state <= ST_RELEASE;
                    end else if (timer == TMR_W'(GRANT_TIMEOUT - 1)) begin
                        grant       <= '0;
                        timeout_err <= 1'b1;
                        state       <= ST_RELEASE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (!busy[owner_id]) begin
                        grant    <= '0;
                        bus_busy <= 1'b0;
                        state    <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
`ifdef MEM_ARB_DCACHE_PRIO_EN
                    if (owner_id != ID_W'(REQ_DCACHE)) begin
                        rr_ptr <= next_ptr;
                    end
`else
                    rr_ptr <= next_ptr;
`endif
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
